reg_xfer_sequencer: RTL and testbench



---
 rtl/reg_xfer_sequencer.sv | 130 +++++++++++++
 tb/tb_reg_xfer_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_sequencer.sv
// Register-to-register transfer initiator: select, settle, load pulse, load release, select release.
// Optional REG_XFER_ERR_EN rejects self-transfers and out-of-range indices with a one-cycle err pulse.
module reg_xfer_sequencer #(
  parameter int SEL_SETTLE = 2,
  parameter int LD_WIDTH   = 2,
  parameter int HOLD       = 1,
  parameter int NREG       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_src,
  input  logic [2:0]      req_dst,
  output logic [NREG-1:0] sel,
  output logic [NREG-1:0] ld,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int MAX_SL = (SEL_SETTLE > LD_WIDTH) ? SEL_SETTLE : LD_WIDTH;
  localparam int MAXP   = (MAX_SL > HOLD) ? MAX_SL : HOLD;
  localparam int CW     = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_LOAD, S_HOLD, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      src, src_nx, dst, dst_nx;
  logic            reject;
  logic            err_nx;
  logic [NREG-1:0] sel_nx, ld_nx;
  logic            busy_nx, done_nx, ready_nx;

`ifdef REG_XFER_ERR_EN
  assign reject = (req_src == req_dst) || (32'(req_src) >= NREG) || (32'(req_dst) >= NREG);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      src       <= '0;
      dst       <= '0;
      sel       <= '0;
      ld        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      src       <= src_nx;
      dst       <= dst_nx;
      sel       <= sel_nx;
      ld        <= ld_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      req_ready <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    src_nx   = src;
    dst_nx   = dst;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (reject) begin
            err_nx = 1'b1;
          end else begin
            state_nx = S_SELECT;
            cnt_nx   = CW'(SEL_SETTLE - 1);
            src_nx   = req_src;
            dst_nx   = req_dst;
          end
        end
      end
      S_SELECT: begin
        if (cnt == '0) begin
          state_nx = S_LOAD;
          cnt_nx   = CW'(LD_WIDTH - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_LOAD: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = CW'(HOLD - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop in step with the state.
  always_comb begin
    sel_nx   = '0;
    ld_nx    = '0;
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_DONE);
    ready_nx = (state_nx == S_IDLE);
    if (state_nx == S_SELECT || state_nx == S_LOAD || state_nx == S_HOLD) begin
      sel_nx = NREG'(1) << src_nx;
    end
    if (state_nx == S_LOAD) begin
      ld_nx = NREG'(1) << dst_nx;
    end
  end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Bench for reg_xfer_sequencer: default-timing and all-ones-timing instances against a cycle-count model.
module tb_reg_xfer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req_valid;
  logic [2:0] req_src, req_dst;
  logic       ready0, busy0, done0, err0;
  logic       ready1, busy1, done1, err1;
  logic [7:0] sel0, ld0, sel1, ld1;

  reg_xfer_sequencer #(.SEL_SETTLE(2), .LD_WIDTH(2), .HOLD(1), .NREG(8)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
    .req_src(req_src), .req_dst(req_dst), .sel(sel0), .ld(ld0),
    .busy(busy0), .done(done0), .err(err0)
  );

  reg_xfer_sequencer #(.SEL_SETTLE(1), .LD_WIDTH(1), .HOLD(1), .NREG(8)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_src(req_src), .req_dst(req_dst), .sel(sel1), .ld(ld1),
    .busy(busy1), .done(done1), .err(err1)
  );

  int errors = 0;
  int checks = 0;

  // Model: k = cycles since the accept edge (0 means idle), plus latched indices and error pulse.
  int         sp[2] = '{2, 1};
  int         lp[2] = '{2, 1};
  int         hp[2] = '{1, 1};
  int         k[2]  = '{0, 0};
  logic [2:0] ls[2];
  logic [2:0] lds[2];
  logic       ep[2] = '{1'b0, 1'b0};

  function automatic logic rej(logic [2:0] s, logic [2:0] d);
`ifdef REG_XFER_ERR_EN
    return (s == d) || (int'(s) >= 8) || (int'(d) >= 8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk8(string tag, int d, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] got=%h want=%h t=%0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic chk1(string tag, int d, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] got=%b want=%b t=%0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int t;
      t = sp[d] + lp[d] + hp[d];
      ep[d] = 1'b0;
      if (reset) begin
        k[d] = 0;
      end else if (k[d] == 0) begin
        if (req_valid) begin
          if (rej(req_src, req_dst)) begin
            ep[d] = 1'b1;
          end else begin
            k[d]   = 1;
            ls[d]  = req_src;
            lds[d] = req_dst;
          end
        end
      end else begin
        k[d] = (k[d] == t + 1) ? 0 : k[d] + 1;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int         t;
      logic [7:0] one, esel, eld;
      t    = sp[d] + lp[d] + hp[d];
      one  = 8'd1;
      esel = (k[d] >= 1 && k[d] <= t) ? (one << ls[d]) : 8'h00;
      eld  = (k[d] >= sp[d] + 1 && k[d] <= sp[d] + lp[d]) ? (one << lds[d]) : 8'h00;
      chk8("sel", d, (d == 0) ? sel0 : sel1, esel);
      chk8("ld", d, (d == 0) ? ld0 : ld1, eld);
      chk1("done", d, (d == 0) ? done0 : done1, k[d] == t + 1);
      chk1("busy", d, (d == 0) ? busy0 : busy1, k[d] != 0);
      chk1("req_ready", d, (d == 0) ? ready0 : ready1, k[d] == 0);
      chk1("err", d, (d == 0) ? err0 : err1, ep[d]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_src   = 3'd0;
    req_dst   = 3'd0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    // X -> A single transfer
    req_valid = 1'b1; req_src = 3'd6; req_dst = 3'd0;
    cycle();
    req_valid = 1'b0; req_src = 3'd2; req_dst = 3'd5;
    repeat (8) cycle();

    // valid held with wandering indices during a transfer
    req_valid = 1'b1; req_src = 3'd6; req_dst = 3'd0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      req_src = 3'($urandom);
      req_dst = 3'($urandom);
    end
    req_valid = 1'b0;
    repeat (8) cycle();

    // reset during the load pulse (observed t1..t3, reset ends t3)
    req_valid = 1'b1; req_src = 3'd6; req_dst = 3'd0;
    cycle();
    req_valid = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();

    // reset wins over a simultaneous accept
    reset = 1'b1; req_valid = 1'b1; req_src = 3'd2; req_dst = 3'd5;
    cycle();
    reset = 1'b0; req_valid = 1'b0;
    repeat (2) cycle();

    // self-transfer D -> D
    req_valid = 1'b1; req_src = 3'd3; req_dst = 3'd3;
    cycle();
    req_valid = 1'b0;
    repeat (8) cycle();

    // back-to-back A -> B then C -> D with valid held
    req_valid = 1'b1; req_src = 3'd0; req_dst = 3'd1;
    cycle();
    req_src = 3'd2; req_dst = 3'd3;
    repeat (14) cycle();
    req_valid = 1'b0;
    repeat (8) cycle();

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_src   = 3'($urandom);
      req_dst   = 3'($urandom);
      reset     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0; req_valid = 1'b0;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
